bus_interconnect: RTL and testbench
===================================

# bus_interconnect

Parametrised single-master, N-slave memory-mapped bus fabric between `cpu` and its peripherals (`bram`, `spram`, `led`, `uart`, future blocks). Decodes the master address against per-slave base/mask pairs, routes read/write strobes, and holds the selected slave for the whole read transaction so the returned data is never mis-steered. It adds unmapped-address and read-timeout error responses. The CPU therefore can never hang on a missing `rd_valid`.

## Interface
- `NSLAVE`, 4: number of slave ports, 1..8.
- `AW`, 16: address width.
- `DW`, 32: data width.
- `SLV_BASE`, {16'h8000,16'h5000,16'h4000,16'h0000}: packed `NSLAVE*AW` base addresses; slave i occupies bits `[i*AW +: AW]`.
- `SLV_MASK`, {16'h8000,16'hF000,16'hF000,16'hC000}: packed decode masks; slave i hits when `(m_addr & mask_i) == base_i`.
- `TIMEOUT`, 255: maximum cycles spent in WAIT before an error response.
- `clk` in 1: single clock; every register samples on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `m_addr` in AW: master address, byte address as issued by `cpu`.
- `m_rd_en` in 1: read request, one-cycle pulse.
- `m_rd_data` out DW: read data; meaningful only while `m_rd_valid`=1.
- `m_rd_valid` out 1: read completion, one-cycle pulse.
- `m_wr_en` in 1: write strobe, one-cycle pulse.
- `m_wr_data` in DW: write data.
- `m_wr_mask` in 4: byte enables.
- `m_err` out 1: error pulse, raised on an unmapped access or a timeout.
- `s_addr` out AW: broadcast to all slaves; equals `m_addr`.
- `s_wr_data` out DW: broadcast to all slaves.
- `s_wr_mask` out 4: broadcast to all slaves.
- `s_rd_en` out NSLAVE: per-slave read strobe.
- `s_wr_en` out NSLAVE: per-slave write strobe.
- `s_rd_data` in NSLAVE*DW: packed slave read data.
- `s_rd_valid` in NSLAVE: per-slave read valid.

## Operation
- Decode is combinational. When several slaves match, the lowest index wins. `hit` = at least one slave matches.
- FSM states are IDLE, WAIT and ERR. Reset state is IDLE.
- IDLE, `m_rd_en` and `hit`:
  - `s_rd_en[sel]` is asserted in the same cycle.
  - `sel` is latched.
  - If `s_rd_valid[sel]` is also high that cycle, the read completes with zero latency and the FSM stays in IDLE. Otherwise it moves to WAIT.
- IDLE, `m_rd_en` and not `hit`: go to ERR.
- WAIT:
  - `m_rd_data = s_rd_data[latched sel]`.
  - `m_rd_valid = s_rd_valid[latched sel]`.
  - `m_addr` may change freely.
  - On valid, return to IDLE.
  - Valids from non-selected slaves are ignored.
- ERR, which lasts exactly one cycle:
  - Drives `m_rd_valid`=1, `m_rd_data`=0 and `m_err`=1.
  - Then returns to IDLE.
- Writes are posted and combinational: `s_wr_en[i] = m_wr_en & sel_i`.
  - A write miss is dropped and pulses `m_err` in the next cycle.
  - Writes are accepted in any state and do not change the FSM.
- `m_rd_en` arriving outside IDLE is a master protocol violation. It is ignored, and no slave strobe is issued.
- Simultaneous `m_rd_en` and `m_wr_en` to the same slave: both strobes are forwarded, and ordering is the slave's concern.
- Reset:
  - While `rst`=1, all `s_rd_en`/`s_wr_en` are forced to 0.
  - `m_rd_valid`=0, `m_err`=0, `m_rd_data`=0.
  - Latched `sel`=0 and the timeout counter is 0.
  - Reset asserted in WAIT abandons the transaction. A late slave valid after reset is ignored.

## Timing
- Read latency is the slave latency plus 0 cycles; the fabric adds no registers on the hit path.
- A read miss completes 1 cycle after `m_rd_en`.
- `m_err` is always a single-cycle pulse.
- Timeout, compiled in via `BUS_TIMEOUT_EN`:
  - The counter clears on entry to WAIT and increments once per WAIT cycle.
  - When it reaches `TIMEOUT`, the FSM moves to ERR, so the error response appears `TIMEOUT`+1 cycles after `m_rd_en`.
  - A slave valid arriving in the same cycle the counter hits `TIMEOUT` wins: normal completion, no error.
- Counter width is `$clog2(TIMEOUT+1)`. It saturates and never wraps.

## Configuration
- `BUS_TIMEOUT_EN` defined: the WAIT watchdog above is present.
- `BUS_TIMEOUT_EN` undefined: no counter. WAIT waits indefinitely for the selected slave, and `m_err` is raised only for unmapped accesses. `TIMEOUT` is unused.

## Structure
- Package `bus_pkg` holds:
  - the FSM state encoding (IDLE/WAIT/ERR);
  - the `SEL_W = $clog2(NSLAVE)` helper;
  - default memory-map constants (BRAM, LED, UART, SPRAM base/mask).
- Sub-module `bus_addr_decode` is a pure combinational decoder that produces `hit` and the `sel` index from `m_addr`, `SLV_BASE` and `SLV_MASK`. The top-level module contains the FSM, timeout and muxing.

## Test plan
- Read 0x0010 to BRAM, which responds 1 cycle later with 0xDEADBEEF → `s_rd_en[0]` pulses; `m_rd_valid`=1 with 0xDEADBEEF one cycle later; `m_err`=0.
- Read 0x8004 to SPRAM, change `m_addr` to 0x4000 before its 3-cycle-late valid → data returned from SPRAM, not LED.
- Read 0x6000 (unmapped) → next cycle `m_rd_valid`=1, `m_rd_data`=0, `m_err`=1. Write to 0x6000 → no `s_wr_en`, `m_err` pulses.
- With `BUS_TIMEOUT_EN` and `TIMEOUT`=8, read UART and never return valid → error response at cycle 9. A valid exactly at count 8 → normal completion.
- Assert `rst` in WAIT, then the slave returns valid → no `m_rd_valid`. A subsequent read to LED completes normally.
- Write 0x5000 with mask 4'b0001 while a BRAM read is in WAIT → `s_wr_en[2]` pulses, and the BRAM read still completes correctly.

Source files
------------

// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - FSM encoding, select-width helper and default memory map for the bus fabric.
package bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR  = 2'd2
  } bus_state_t;

  // Select index width; a single-slave fabric still needs a 1-bit index.
  function automatic int sel_w(input int nslave);
    return (nslave > 1) ? $clog2(nslave) : 1;
  endfunction

  localparam logic [15:0] BRAM_BASE  = 16'h0000;
  localparam logic [15:0] BRAM_MASK  = 16'hC000;
  localparam logic [15:0] LED_BASE   = 16'h4000;
  localparam logic [15:0] LED_MASK   = 16'hF000;
  localparam logic [15:0] UART_BASE  = 16'h5000;
  localparam logic [15:0] UART_MASK  = 16'hF000;
  localparam logic [15:0] SPRAM_BASE = 16'h8000;
  localparam logic [15:0] SPRAM_MASK = 16'h8000;

endpackage

// File: rtl/bus_addr_decode.sv
// rtl/bus_addr_decode.sv - Combinational base/mask address decoder; lowest matching slave wins.
module bus_addr_decode
  import bus_pkg::*;
#(
  parameter int                   NSLAVE   = 4,
  parameter int                   AW       = 16,
  parameter logic [NSLAVE*AW-1:0] SLV_BASE = '0,
  parameter logic [NSLAVE*AW-1:0] SLV_MASK = '0,
  parameter int                   SW       = sel_w(NSLAVE)
) (
  input  logic [AW-1:0] addr,
  output logic          hit,
  output logic [SW-1:0] sel
);

  // Scan from the top so the lowest matching index is the last one written.
  always_comb begin
    hit = 1'b0;
    sel = '0;
    for (int i = NSLAVE - 1; i >= 0; i--) begin
      if ((addr & SLV_MASK[i*AW +: AW]) == SLV_BASE[i*AW +: AW]) begin
        hit = 1'b1;
        sel = SW'(i);
      end
    end
  end

endmodule

// File: rtl/bus_interconnect.sv
// rtl/bus_interconnect.sv - Single-master N-slave bus fabric with read steering and error responses; BUS_TIMEOUT_EN adds a WAIT watchdog.
module bus_interconnect
  import bus_pkg::*;
#(
  parameter int                   NSLAVE   = 4,
  parameter int                   AW       = 16,
  parameter int                   DW       = 32,
  parameter logic [NSLAVE*AW-1:0] SLV_BASE = {SPRAM_BASE, UART_BASE, LED_BASE, BRAM_BASE},
  parameter logic [NSLAVE*AW-1:0] SLV_MASK = {SPRAM_MASK, UART_MASK, LED_MASK, BRAM_MASK},
  parameter int                   TIMEOUT  = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [AW-1:0]        m_addr,
  input  logic                 m_rd_en,
  output logic [DW-1:0]        m_rd_data,
  output logic                 m_rd_valid,
  input  logic                 m_wr_en,
  input  logic [DW-1:0]        m_wr_data,
  input  logic [3:0]           m_wr_mask,
  output logic                 m_err,
  output logic [AW-1:0]        s_addr,
  output logic [DW-1:0]        s_wr_data,
  output logic [3:0]           s_wr_mask,
  output logic [NSLAVE-1:0]    s_rd_en,
  output logic [NSLAVE-1:0]    s_wr_en,
  input  logic [NSLAVE*DW-1:0] s_rd_data,
  input  logic [NSLAVE-1:0]    s_rd_valid
);

  localparam int SW = sel_w(NSLAVE);

  bus_state_t    state_q, state_d;
  logic [SW-1:0] sel_q, sel_d;
  logic [SW-1:0] dec_sel;
  logic          dec_hit;
  logic          wr_err_q;
  logic          rd_err;
  logic          timeout_hit;
  logic [DW-1:0] slv_data [NSLAVE];

  bus_addr_decode #(
    .NSLAVE   (NSLAVE),
    .AW       (AW),
    .SLV_BASE (SLV_BASE),
    .SLV_MASK (SLV_MASK),
    .SW       (SW)
  ) u_decode (
    .addr (m_addr),
    .hit  (dec_hit),
    .sel  (dec_sel)
  );

  assign s_addr    = m_addr;
  assign s_wr_data = m_wr_data;
  assign s_wr_mask = m_wr_mask;

  always_comb begin
    for (int i = 0; i < NSLAVE; i++) begin
      slv_data[i] = s_rd_data[i*DW +: DW];
    end
  end

  // Posted writes follow the live address, independent of any read in flight.
  always_comb begin
    for (int i = 0; i < NSLAVE; i++) begin
      s_wr_en[i] = ~rst & m_wr_en & dec_hit & (dec_sel == SW'(i));
    end
  end

`ifdef BUS_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_inc;

  // Counts WAIT cycles including the current one; saturates instead of wrapping.
  assign cnt_inc     = (cnt_q == {CW{1'b1}}) ? cnt_q : cnt_q + 1'b1;
  assign timeout_hit = (state_q == ST_WAIT) && (cnt_inc >= CW'(TIMEOUT));

  always_ff @(posedge clk) begin
    if (rst || state_q != ST_WAIT) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_inc;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    s_rd_en    = '0;
    m_rd_valid = 1'b0;
    m_rd_data  = '0;
    rd_err     = 1'b0;
    if (!rst) begin
      case (state_q)
        ST_IDLE: begin
          if (m_rd_en) begin
            if (dec_hit) begin
              for (int i = 0; i < NSLAVE; i++) begin
                s_rd_en[i] = (dec_sel == SW'(i));
              end
              sel_d = dec_sel;
              if (s_rd_valid[dec_sel]) begin
                m_rd_valid = 1'b1;
                m_rd_data  = slv_data[dec_sel];
              end else begin
                state_d = ST_WAIT;
              end
            end else begin
              state_d = ST_ERR;
            end
          end
        end
        ST_WAIT: begin
          m_rd_data  = slv_data[sel_q];
          m_rd_valid = s_rd_valid[sel_q];
          // A valid in the expiry cycle still completes normally.
          if (s_rd_valid[sel_q]) begin
            state_d = ST_IDLE;
          end else if (timeout_hit) begin
            state_d = ST_ERR;
          end
        end
        ST_ERR: begin
          m_rd_valid = 1'b1;
          rd_err     = 1'b1;
          state_d    = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  assign m_err = ~rst & (rd_err | wr_err_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      sel_q    <= '0;
      wr_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      wr_err_q <= m_wr_en & ~dec_hit;
    end
  end

endmodule

// File: tb/tb_bus_interconnect.sv
// tb/tb_bus_interconnect.sv - Directed self-checking bench for bus_interconnect.
module tb_bus_interconnect;

  logic         clk = 1'b0;
  logic         rst;
  logic [15:0]  m_addr;
  logic         m_rd_en;
  logic [31:0]  m_rd_data;
  logic         m_rd_valid;
  logic         m_wr_en;
  logic [31:0]  m_wr_data;
  logic [3:0]   m_wr_mask;
  logic         m_err;
  logic [15:0]  s_addr;
  logic [31:0]  s_wr_data;
  logic [3:0]   s_wr_mask;
  logic [3:0]   s_rd_en;
  logic [3:0]   s_wr_en;
  logic [127:0] s_rd_data;
  logic [3:0]   s_rd_valid;

  int n_cmp = 0;
  int n_bad = 0;

  bus_interconnect #(
    .NSLAVE  (4),
    .AW      (16),
    .DW      (32),
    .TIMEOUT (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .m_addr     (m_addr),
    .m_rd_en    (m_rd_en),
    .m_rd_data  (m_rd_data),
    .m_rd_valid (m_rd_valid),
    .m_wr_en    (m_wr_en),
    .m_wr_data  (m_wr_data),
    .m_wr_mask  (m_wr_mask),
    .m_err      (m_err),
    .s_addr     (s_addr),
    .s_wr_data  (s_wr_data),
    .s_wr_mask  (s_wr_mask),
    .s_rd_en    (s_rd_en),
    .s_wr_en    (s_wr_en),
    .s_rd_data  (s_rd_data),
    .s_rd_valid (s_rd_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge and drop all one-cycle strobes.
  task automatic next_cycle();
    @(posedge clk);
    #1;
    m_rd_en    = 1'b0;
    m_wr_en    = 1'b0;
    s_rd_valid = 4'b0000;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic set_data(input int idx, input logic [31:0] v);
    s_rd_data[idx*32 +: 32] = v;
  endtask

  initial begin
    rst        = 1'b1;
    m_addr     = 16'h0000;
    m_rd_en    = 1'b0;
    m_wr_en    = 1'b0;
    m_wr_data  = 32'h0;
    m_wr_mask  = 4'h0;
    s_rd_data  = '0;
    s_rd_valid = 4'b0000;

    // Reset: strobes and responses held low even with activity on the inputs
    next_cycle();
    m_addr = 16'h0010; m_rd_en = 1'b1; m_wr_en = 1'b1;
    s_rd_valid = 4'b0001; set_data(0, 32'hA5A5A5A5);
    mid();
    chk("rst_s_rd_en", {28'h0, s_rd_en}, 32'h0);
    chk("rst_s_wr_en", {28'h0, s_wr_en}, 32'h0);
    chk("rst_valid", {31'h0, m_rd_valid}, 32'h0);
    chk("rst_err", {31'h0, m_err}, 32'h0);
    chk("rst_data", m_rd_data, 32'h0);
    next_cycle();
    rst = 1'b0;
    mid();
    chk("post_rst_err", {31'h0, m_err}, 32'h0);

    // BRAM read, one-cycle slave latency
    next_cycle();
    m_addr = 16'h0010; m_rd_en = 1'b1;
    mid();
    chk("bram_rd_en", {28'h0, s_rd_en}, 32'h1);
    chk("bram_no_valid_yet", {31'h0, m_rd_valid}, 32'h0);
    chk("s_addr_bcast", {16'h0, s_addr}, 32'h0010);
    next_cycle();
    s_rd_valid = 4'b0001; set_data(0, 32'hDEADBEEF);
    mid();
    chk("bram_valid", {31'h0, m_rd_valid}, 32'h1);
    chk("bram_data", m_rd_data, 32'hDEADBEEF);
    chk("bram_err", {31'h0, m_err}, 32'h0);
    chk("bram_rd_en_done", {28'h0, s_rd_en}, 32'h0);
    next_cycle();
    mid();
    chk("bram_valid_pulse", {31'h0, m_rd_valid}, 32'h0);

    // LED zero-latency read, then an immediate follow-on read proves IDLE
    next_cycle();
    m_addr = 16'h4000; m_rd_en = 1'b1; s_rd_valid = 4'b0010; set_data(1, 32'h11112222);
    mid();
    chk("zl_rd_en", {28'h0, s_rd_en}, 32'h2);
    chk("zl_valid", {31'h0, m_rd_valid}, 32'h1);
    chk("zl_data", m_rd_data, 32'h11112222);
    next_cycle();
    m_addr = 16'h4004; m_rd_en = 1'b1;
    mid();
    chk("zl_back2back_rd_en", {28'h0, s_rd_en}, 32'h2);
    chk("zl_back2back_valid", {31'h0, m_rd_valid}, 32'h0);
    next_cycle();
    s_rd_valid = 4'b0010; set_data(1, 32'h33334444);
    mid();
    chk("zl_b2b_data", m_rd_data, 32'h33334444);

    // SPRAM read held while address moves to LED and LED raises valid
    next_cycle();
    m_addr = 16'h8004; m_rd_en = 1'b1;
    mid();
    chk("spram_rd_en", {28'h0, s_rd_en}, 32'h8);
    next_cycle();
    m_addr = 16'h4000; s_rd_valid = 4'b0010; set_data(1, 32'hBAD0BAD0);
    mid();
    chk("spram_ignore_led_valid", {31'h0, m_rd_valid}, 32'h0);
    next_cycle();
    m_rd_en = 1'b1; s_rd_valid = 4'b0010;
    mid();
    chk("spram_rd_in_wait_ignored", {28'h0, s_rd_en}, 32'h0);
    chk("spram_still_waiting", {31'h0, m_rd_valid}, 32'h0);
    next_cycle();
    s_rd_valid = 4'b1000; set_data(3, 32'hCAFEF00D);
    mid();
    chk("spram_valid", {31'h0, m_rd_valid}, 32'h1);
    chk("spram_data", m_rd_data, 32'hCAFEF00D);

    // Unmapped read
    next_cycle();
    m_addr = 16'h6000; m_rd_en = 1'b1;
    mid();
    chk("miss_rd_no_strobe", {28'h0, s_rd_en}, 32'h0);
    chk("miss_rd_no_valid", {31'h0, m_rd_valid}, 32'h0);
    next_cycle();
    set_data(0, 32'h77777777);
    mid();
    chk("miss_rd_valid", {31'h0, m_rd_valid}, 32'h1);
    chk("miss_rd_data", m_rd_data, 32'h0);
    chk("miss_rd_err", {31'h0, m_err}, 32'h1);
    next_cycle();
    mid();
    chk("miss_rd_err_pulse", {31'h0, m_err}, 32'h0);

    // Unmapped write
    next_cycle();
    m_addr = 16'h6000; m_wr_en = 1'b1; m_wr_data = 32'h0BADF00D; m_wr_mask = 4'hF;
    mid();
    chk("miss_wr_no_strobe", {28'h0, s_wr_en}, 32'h0);
    chk("miss_wr_err_late", {31'h0, m_err}, 32'h0);
    next_cycle();
    mid();
    chk("miss_wr_err", {31'h0, m_err}, 32'h1);
    next_cycle();
    mid();
    chk("miss_wr_err_pulse", {31'h0, m_err}, 32'h0);

`ifdef BUS_TIMEOUT_EN
    // UART never answers: error response 9 cycles after the request
    next_cycle();
    m_addr = 16'h5000; m_rd_en = 1'b1;
    mid();
    for (int c = 1; c <= 8; c++) begin
      next_cycle();
      mid();
      chk($sformatf("to_quiet_c%0d", c), {30'h0, m_err, m_rd_valid}, 32'h0);
    end
    next_cycle();
    mid();
    chk("to_valid", {31'h0, m_rd_valid}, 32'h1);
    chk("to_err", {31'h0, m_err}, 32'h1);
    chk("to_data", m_rd_data, 32'h0);
    // Valid in the expiry cycle wins
    next_cycle();
    m_addr = 16'h5000; m_rd_en = 1'b1;
    mid();
    for (int c = 1; c <= 7; c++) begin
      next_cycle();
      mid();
    end
    next_cycle();
    s_rd_valid = 4'b0100; set_data(2, 32'h0000AAAA);
    mid();
    chk("to_edge_valid", {31'h0, m_rd_valid}, 32'h1);
    chk("to_edge_no_err", {31'h0, m_err}, 32'h0);
    chk("to_edge_data", m_rd_data, 32'h0000AAAA);
    next_cycle();
    mid();
    chk("to_edge_after", {30'h0, m_err, m_rd_valid}, 32'h0);
`else
    // Without the watchdog a slow UART is waited for indefinitely
    next_cycle();
    m_addr = 16'h5000; m_rd_en = 1'b1;
    mid();
    for (int c = 1; c <= 20; c++) begin
      next_cycle();
      mid();
      chk($sformatf("slow_quiet_c%0d", c), {30'h0, m_err, m_rd_valid}, 32'h0);
    end
    next_cycle();
    s_rd_valid = 4'b0100; set_data(2, 32'h0000AAAA);
    mid();
    chk("slow_valid", {31'h0, m_rd_valid}, 32'h1);
    chk("slow_data", m_rd_data, 32'h0000AAAA);
    chk("slow_no_err", {31'h0, m_err}, 32'h0);
`endif

    // Reset in WAIT abandons the read; late valid is ignored
    next_cycle();
    m_addr = 16'h4000; m_rd_en = 1'b1;
    mid();
    next_cycle();
    rst = 1'b1;
    mid();
    chk("rstwait_valid", {31'h0, m_rd_valid}, 32'h0);
    next_cycle();
    rst = 1'b0; s_rd_valid = 4'b0010; set_data(1, 32'h99999999);
    mid();
    chk("rstwait_late_valid", {31'h0, m_rd_valid}, 32'h0);
    next_cycle();
    m_addr = 16'h4008; m_rd_en = 1'b1;
    mid();
    chk("rstwait_new_rd_en", {28'h0, s_rd_en}, 32'h2);
    next_cycle();
    s_rd_valid = 4'b0010; set_data(1, 32'h00C0FFEE);
    mid();
    chk("rstwait_new_valid", {31'h0, m_rd_valid}, 32'h1);
    chk("rstwait_new_data", m_rd_data, 32'h00C0FFEE);

    // Posted write to UART while a BRAM read waits
    next_cycle();
    m_addr = 16'h0020; m_rd_en = 1'b1;
    mid();
    next_cycle();
    m_addr = 16'h5000; m_wr_en = 1'b1; m_wr_data = 32'h00000055; m_wr_mask = 4'b0001;
    mid();
    chk("wr_in_wait_en", {28'h0, s_wr_en}, 32'h4);
    chk("wr_in_wait_mask", {28'h0, s_wr_mask}, 32'h1);
    chk("wr_in_wait_data", s_wr_data, 32'h00000055);
    chk("wr_in_wait_no_rd", {28'h0, s_rd_en}, 32'h0);
    next_cycle();
    s_rd_valid = 4'b0001; set_data(0, 32'h12345678);
    mid();
    chk("wr_in_wait_rd_valid", {31'h0, m_rd_valid}, 32'h1);
    chk("wr_in_wait_rd_data", m_rd_data, 32'h12345678);
    chk("wr_in_wait_no_err", {31'h0, m_err}, 32'h0);

    // Simultaneous read and write to BRAM forward both strobes
    next_cycle();
    m_addr = 16'h0030; m_rd_en = 1'b1; m_wr_en = 1'b1; m_wr_mask = 4'hF;
    mid();
    chk("rdwr_rd_en", {28'h0, s_rd_en}, 32'h1);
    chk("rdwr_wr_en", {28'h0, s_wr_en}, 32'h1);
    next_cycle();
    s_rd_valid = 4'b0001; set_data(0, 32'h0BEEF000);
    mid();
    chk("rdwr_data", m_rd_data, 32'h0BEEF000);
    chk("rdwr_no_err", {31'h0, m_err}, 32'h0);

    next_cycle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
